strobe_fifo: RTL

STROBE_FIFO -- requirements
Module: strobe_fifo

---
 rtl/fifo_ram.sv | 31 +++
 rtl/strobe_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port word storage for strobe_fifo.
//   clk      - write clock (rising edge)
//   wr_en    - write enable for the synchronous write port
//   wr_addr  - write address
//   wr_data  - write word
//   rd_addr  - asynchronous read address
//   rd_data  - word stored at rd_addr (combinational read)
module fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/strobe_fifo.sv
// strobe_fifo: queue fed by single-cycle write strobes, drained by a
// valid/ready consumer. Drops strobes when full and flags them stickily.
//   clk            - sole clock, rising edge
//   reset          - synchronous, active-high
//   strobe_in      - one-cycle write qualifier
//   data_in        - word captured when strobe_in=1
//   data_out       - head-of-queue word (meaningful when valid_out=1)
//   valid_out      - queue non-empty
//   ready_in       - consumer accepts data_out this cycle
//   count          - occupancy 0..DEPTH
//   almost_full    - DEPTH-count <= ALMOST
//   overflow       - sticky: a strobe was dropped
//   overflow_clear - clears overflow (a same-cycle drop wins)
module strobe_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ALMOST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     strobe_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clear
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic pop_c;
  logic full_c;
  logic wr_acc_c;
  logic drop_c;

  // Pop only from a non-empty queue; a write into an empty queue is not
  // visible to the consumer until the following cycle.
  assign pop_c    = (count_q != '0) && ready_in;
  assign full_c   = (count_q == CW'(DEPTH));
  assign wr_acc_c = strobe_in && (!full_c || pop_c);
  assign drop_c   = strobe_in && full_c && !pop_c;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({wr_acc_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end else if (overflow_clear) begin
      overflow_q <= 1'b0;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_c && !reset),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign count       = count_q;
  assign valid_out   = (count_q != '0);
  assign overflow    = overflow_q;
  assign almost_full = ((32'(DEPTH) - 32'(count_q)) <= 32'(ALMOST));

endmodule
